// File: rtl/glb_stream_pkg.sv
// Shared definitions for the sparse-unit GLB stream interface.
// Used by the GLB stream sink and its helpers.
package glb_stream_pkg;

    localparam int GLB_DATA_W = 17;
    localparam logic [GLB_DATA_W-1:0] GLB_DONE_TOKEN = 17'h10100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_ARM,
        ST_RECV,
        ST_DONE
    } glb_rd_state_t;

endpackage

// File: rtl/glb_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only when enabled.
// Drives the pseudo-random backpressure of the GLB stream sink.
module glb_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        fb;

    always_comb begin
        fb      = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
        state_d = state_q;
        if (en) begin
            state_d = {state_q[14:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/glb_read.sv
// GLB stream sink: captures accepted words into a local buffer, counts done
// tokens and flags completion or overflow; contents are read back afterwards.
module glb_read
    import glb_stream_pkg::*;
#(
    parameter int          TX_SIZE     = 2048,
    parameter int          TX_NUM      = 1,
    parameter int          STALL_EN    = 0,
    parameter int          STALL_SHIFT = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [GLB_DATA_W-1:0]        data,
    input  logic                         valid,
    output logic                         ready,
    output logic                         done,
    output logic                         overflow,
    input  logic                         flush,
    output logic [$clog2(TX_SIZE):0]     count,
    input  logic [$clog2(TX_SIZE)-1:0]   rd_addr,
    output logic [GLB_DATA_W-1:0]        rd_data
);

    localparam int AW = $clog2(TX_SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(TX_SIZE - 1);
    localparam logic [7:0]    TOK_TARGET = 8'(TX_NUM);
    localparam logic [15:0]   STALL_MASK = 16'h3 << STALL_SHIFT;

    glb_rd_state_t   state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      tok_q, tok_d;
    logic [1:0]      arm_q, arm_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [GLB_DATA_W-1:0] rd_data_q, rd_data_d;

    logic [GLB_DATA_W-1:0] mem [TX_SIZE];

    logic [15:0] lfsr;
    logic        stall;
    logic        accept;
    logic        is_token;

    glb_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q == ST_RECV),
        .state(lfsr)
    );

    // ready depends on registered state only, never on valid/data
    assign stall    = (STALL_EN != 0) && ((lfsr & STALL_MASK) != 16'h0);
    assign ready    = (state_q == ST_RECV) && !stall;
    assign accept   = ready && valid && !flush;
    assign is_token = (data == GLB_DONE_TOKEN);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tok_d   = tok_q;
        arm_d   = arm_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (flush) begin
            state_d = ST_FLUSH;
            count_d = '0;
            tok_d   = '0;
            arm_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    state_d = ST_ARM;
                    arm_d   = 2'd2;
                end
                ST_ARM: begin
                    if (arm_q == 2'd0) begin
                        state_d = ST_RECV;
                    end else begin
                        arm_d = arm_q - 2'd1;
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        count_d = count_q + 1'b1;
                        if (is_token) begin
                            tok_d = tok_q + 8'd1;
                        end
                        // token completion takes priority over a full buffer
                        if (is_token && (tok_q + 8'd1 == TOK_TARGET)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if (count_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            ovf_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tok_q   <= '0;
            arm_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tok_q   <= tok_d;
            arm_q   <= arm_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem[count_q[AW-1:0]] <= data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign done     = done_q;
    assign overflow = ovf_q;
    assign count    = count_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_glb_read.sv
// Bench for glb_read: four instances cover token counts, overflow and
// backpressure; a transfer-level model predicts captured words and flags.
module tb_glb_read;

    localparam logic [16:0] TOKEN = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  flush_v;
    logic [3:0]  valid_v;
    logic [3:0]  ready_v;
    logic [3:0]  done_v;
    logic [3:0]  ovf_v;
    logic [16:0] data_v    [4];
    logic [16:0] rd_data_v [4];
    logic [7:0]  rd_addr_v [4];
    logic [8:0]  cnt_a, cnt_b, cnt_d;
    logic [2:0]  cnt_c;
    logic [11:0] count_v   [4];

    int tx_num  [4] = '{1, 2, 1, 1};
    int tx_size [4] = '{256, 256, 4, 256};

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] stim_q [$];
    logic [16:0] exp_q  [$];
    int m_words, m_tokens;
    bit m_done, m_ovf;
    bit saw_rdy0, saw_rdy1;

    always #5 clk = ~clk;

    assign count_v[0] = {3'b0, cnt_a};
    assign count_v[1] = {3'b0, cnt_b};
    assign count_v[2] = {9'b0, cnt_c};
    assign count_v[3] = {3'b0, cnt_d};

    glb_read #(.TX_SIZE(256), .TX_NUM(1)) u_a (
        .clk(clk), .rst_n(rst_n), .data(data_v[0]), .valid(valid_v[0]),
        .ready(ready_v[0]), .done(done_v[0]), .overflow(ovf_v[0]),
        .flush(flush_v[0]), .count(cnt_a), .rd_addr(rd_addr_v[0]),
        .rd_data(rd_data_v[0]));

    glb_read #(.TX_SIZE(256), .TX_NUM(2)) u_b (
        .clk(clk), .rst_n(rst_n), .data(data_v[1]), .valid(valid_v[1]),
        .ready(ready_v[1]), .done(done_v[1]), .overflow(ovf_v[1]),
        .flush(flush_v[1]), .count(cnt_b), .rd_addr(rd_addr_v[1]),
        .rd_data(rd_data_v[1]));

    glb_read #(.TX_SIZE(4), .TX_NUM(1)) u_c (
        .clk(clk), .rst_n(rst_n), .data(data_v[2]), .valid(valid_v[2]),
        .ready(ready_v[2]), .done(done_v[2]), .overflow(ovf_v[2]),
        .flush(flush_v[2]), .count(cnt_c), .rd_addr(rd_addr_v[2][1:0]),
        .rd_data(rd_data_v[2]));

    glb_read #(.TX_SIZE(256), .TX_NUM(1), .STALL_EN(1), .STALL_SHIFT(0)) u_d (
        .clk(clk), .rst_n(rst_n), .data(data_v[3]), .valid(valid_v[3]),
        .ready(ready_v[3]), .done(done_v[3]), .overflow(ovf_v[3]),
        .flush(flush_v[3]), .count(cnt_d), .rd_addr(rd_addr_v[3]),
        .rd_data(rd_data_v[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] rnd_word();
        logic [16:0] w;
        w = 17'($urandom_range(0, 32'h1FFFF));
        if (w == TOKEN) w = 17'h00001;
        return w;
    endfunction

    task automatic do_flush(input int k, input bit rise_chk);
        @(negedge clk);
        flush_v[k] = 1'b1;
        valid_v[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("flush_done", done_v[k], 0);
        check("flush_ovf", ovf_v[k], 0);
        check("flush_count", count_v[k], 0);
        flush_v[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) check("arm_ready", ready_v[k], 0);
            else if (rise_chk) check("ready_rise", ready_v[k], 1);
        end
        exp_q.delete();
        m_words  = 0;
        m_tokens = 0;
        m_done   = 0;
        m_ovf    = 0;
    endtask

    // Drives stim_q into instance k; the model records each accepted word.
    task automatic send(input int k, input int max_acc, input bit rand_valid);
        int budget = 5000;
        int acc_n  = 0;
        logic rdy;
        logic [16:0] w;
        saw_rdy0 = 0;
        saw_rdy1 = 0;
        while (stim_q.size() > 0 && acc_n < max_acc && !m_done && budget > 0) begin
            @(negedge clk);
            check("done_run", done_v[k], 32'(m_done));
            data_v[k]  = stim_q[0];
            valid_v[k] = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = ready_v[k];
            if (rdy) saw_rdy1 = 1; else saw_rdy0 = 1;
            @(posedge clk);
            if (valid_v[k] && rdy) begin
                w = stim_q.pop_front();
                exp_q.push_back(w);
                m_words++;
                if (w == TOKEN) m_tokens++;
                if (m_tokens == tx_num[k]) m_done = 1;
                else if (m_words == tx_size[k]) begin
                    m_done = 1;
                    m_ovf  = 1;
                end
                acc_n++;
            end
            budget--;
        end
        if (budget == 0) check("send_budget", 0, 1);
        @(negedge clk);
        valid_v[k] = 1'b0;
        check("end_done", done_v[k], 32'(m_done));
        check("end_ovf", ovf_v[k], 32'(m_ovf));
        check("end_count", count_v[k], exp_q.size());
        if (m_done) check("end_ready", ready_v[k], 0);
    endtask

    task automatic read_chk(input int k, input int addr, input logic [16:0] exp);
        @(negedge clk);
        rd_addr_v[k] = 8'(addr);
        @(negedge clk);
        check("rd_data", rd_data_v[k], exp);
    endtask

    task automatic read_all(input int k);
        for (int i = 0; i < exp_q.size(); i++) read_chk(k, i, exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        flush_v = '0;
        valid_v = '0;
        for (int i = 0; i < 4; i++) begin
            data_v[i]    = '0;
            rd_addr_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", ready_v[i], 0);
            check("rst_done", done_v[i], 0);
            check("rst_ovf", ovf_v[i], 0);
            check("rst_count", count_v[i], 0);
            check("rst_rd_data", rd_data_v[i], 0);
        end
        rst_n = 1'b1;

        // basic transfer: 5, 7, token
        do_flush(0, 1);
        stim_q = '{17'd5, 17'd7, TOKEN};
        send(0, 1000, 0);
        read_all(0);

        // two tokens needed
        do_flush(1, 1);
        stim_q = '{17'd1, TOKEN, 17'd2, TOKEN};
        send(1, 1000, 0);
        read_all(1);

        // overflow on a 4-word buffer, then a 5th valid is ignored
        do_flush(2, 1);
        stim_q.delete();
        for (int i = 0; i < 5; i++) stim_q.push_back(rnd_word());
        send(2, 1000, 0);
        @(negedge clk);
        data_v[2]  = stim_q[0];
        valid_v[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("ovf_hold_count", count_v[2], 4);
        check("ovf_hold_ready", ready_v[2], 0);
        check("ovf_hold_done", done_v[2], 1);
        valid_v[2] = 1'b0;
        read_all(2);

        // random backpressure, random valid gaps
        do_flush(3, 0);
        stim_q.delete();
        for (int i = 0; i < 99; i++) stim_q.push_back(rnd_word());
        stim_q.push_back(TOKEN);
        send(3, 1000, 1);
        check("stall_toggle", 32'(saw_rdy0 && saw_rdy1), 1);
        check("stall_words", exp_q.size(), 100);
        read_all(3);

        // partial transfer interrupted by flush, then restarted
        do_flush(0, 1);
        stim_q.delete();
        for (int i = 0; i < 14; i++) stim_q.push_back(rnd_word());
        send(0, 10, 0);
        check("partial_count", count_v[0], 10);
        do_flush(0, 1);
        stim_q = '{rnd_word(), rnd_word(), rnd_word(), TOKEN};
        send(0, 1000, 0);
        check("restart_count", count_v[0], 4);
        read_all(0);

        // reset in RECV together with valid
        do_flush(0, 1);
        stim_q = '{rnd_word(), rnd_word(), rnd_word()};
        send(0, 3, 0);
        rd_addr_v[0] = 8'd1;
        @(negedge clk);
        rst_n      = 1'b0;
        valid_v[0] = 1'b1;
        data_v[0]  = TOKEN;
        @(negedge clk);
        check("mid_rst_ready", ready_v[0], 0);
        check("mid_rst_done", done_v[0], 0);
        check("mid_rst_ovf", ovf_v[0], 0);
        check("mid_rst_count", count_v[0], 0);
        check("mid_rst_rd_data", rd_data_v[0], 0);
        rst_n = 1'b1;
        saw_rdy1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_v[0]) saw_rdy1 = 1;
        end
        check("post_rst_ready", 32'(saw_rdy1), 0);
        check("post_rst_count", count_v[0], 0);
        valid_v[0] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/glb_read.md
# glb_read

Synthesizable stream sink for the sparse-unit GLB interface: accepts the 17-bit ready/valid token stream a GLB writer produces, stores every accepted word in a local buffer, counts done tokens and raises `done` once the expected number has arrived. It sits at the output end of a sparse datapath under test. It provides optional pseudo-random backpressure and a registered readback port so a bench can check captured contents after `done`.

## Interface
- `TX_SIZE`, 2048, buffer depth in words; also the maximum number of accepted words.
- `TX_NUM`, 1, number of done tokens (17'h10100) that end the transfer; range 1..255.
- `STALL_EN`, 0, 1 enables LFSR-driven backpressure.
- `STALL_SHIFT`, 0, stall mask is 2'b11 << `STALL_SHIFT`; range 0..14.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be nonzero.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data`  in  17  stream word; bit 16 marks a control token.
- `valid`  in  1  `data` is valid.
- `ready`  out  1  sink accepts `data` this cycle.
- `done`  out  1  transfer complete; sticky until flush or reset.
- `overflow`  out  1  buffer filled before `TX_NUM` done tokens arrived; sticky.
- `flush`  in  1  level; arms and restarts the sink.
- `count`  out  $clog2(TX_SIZE)+1  words accepted since the last flush.
- `rd_addr`  in  $clog2(TX_SIZE)  readback address.
- `rd_data`  out  17  `mem[rd_addr]`, one cycle latency.

## Operation
- States: IDLE, FLUSH, ARM, RECV, DONE.
- IDLE: entered from reset. Moves to FLUSH on the first edge that samples `flush`=1.
- Any state except IDLE: `flush`=1 sampled → FLUSH. This clears `count`, the token counter, `done`, `overflow` and the ARM counter. Buffer contents are not cleared.
- FLUSH → ARM on the first edge that samples `flush`=0; the ARM counter loads 2.
- ARM: counter decrements each cycle; at 0 → RECV. RECV is therefore entered on the 3rd edge after the first `flush`=0 sample.
- RECV handshake: `valid`&&`ready` at an edge writes `data` to `mem[count]` and increments `count`.
- If the accepted word equals 17'h10100, the token counter increments. When this brings the counter to `TX_NUM` → DONE.
- If an accept makes `count`==`TX_SIZE` and the token condition is not met → DONE with `overflow`=1.
- If the final done token also fills the buffer, `done`=1 and `overflow`=0.
- Backpressure: the 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle in RECV, and its value is held in other states. stall = `STALL_EN` && ((lfsr & (16'h3 << `STALL_SHIFT)) != 0).
- `ready` = (state==RECV) && !stall. It is decoded from registers only, with no combinational path from `valid` or `data`.
- DONE: `ready`=0, `done`=1; the sink ignores `valid`. Leaves DONE only on `flush` or reset.
- Words with bit 16 set that are not 17'h10100 (stop tokens etc.) are stored and counted like data.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `ready`=0, `done`=0, `overflow`=0, `count`=0, token counter 0, LFSR=`LFSR_SEED`, `rd_data`=0. Buffer is not reset.
- Reset overrides `flush` and handshakes in the same cycle. Reset mid-transfer discards progress; the sink needs a new flush pulse.
- `done`/`overflow` rise in the cycle after the edge that accepts the final word; `ready` falls in the same cycle.
- `count` updates in the cycle after each accept.
- `rd_data` is valid one cycle after `rd_addr` is presented. A read of the address being written in the same edge returns the old value.
- `flush` and a handshake at the same edge: flush wins and the word is not stored.
- Throughput with `STALL_EN`=0: one word per cycle.

## Structure
- Package `glb_stream_pkg` holds:
  - `GLB_DATA_W`=17
  - `GLB_DONE_TOKEN`=17'h10100
  - the state enum `glb_rd_state_t`
- Sub-module `glb_lfsr16` (seed parameter, `en` input, 16-bit state output). `glb_read` instantiates it once.
- The buffer is an inferred single-write, single-registered-read array.

## Test plan
- Reset, pulse `flush` for 2 cycles, then send 5, 7, 17'h10100 with `valid` held high and `TX_NUM`=1 → `ready` rises 3 cycles after `flush` falls; `count`=3; `done`=1 the cycle after the token is accepted; readback addresses 0..2 return 5, 7, 17'h10100.
- `TX_NUM`=2, stream 1, 17'h10100, 2, 17'h10100 → `done` stays 0 after the first token and goes to 1 after the second; `count`=4.
- `TX_SIZE`=4, send 4 data words with no token → `overflow`=1, `done`=1, `ready`=0; a 5th `valid` is not accepted.
- `STALL_EN`=1, `STALL_SHIFT`=0, 100-word stream ending in a done token → `ready` toggles; all 100 words are read back in order; no word is accepted while `ready`=0.
- Assert `flush` after 10 accepts (partial transfer), then resend 3 words plus a token → `count` restarts at 0 and ends at 4; `done` clears during flush and then asserts.
- Assert `rst_n`=0 in RECV together with `valid` → all outputs return to reset values the next cycle, and `ready` stays 0 until a new flush sequence.
